text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/gpu_pkg.sv | 45 ++++
 rtl/text_console_if.sv | 11 +
 rtl/text_console_mover.sv | 101 ++++++++++
 rtl/text_console.sv | 219 +++++++++++++++++++++
 tb/tb_text_console.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared constants, types and the cell-index helper for the text console.
// Geometry defaults, control codes and register offsets are defined once here.
package gpu_pkg;

  localparam int COLS_DEF  = 80;
  localparam int ROWS_DEF  = 30;
  localparam int CELLS_DEF = COLS_DEF * ROWS_DEF;

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_PR_LO = 8'h20;
  localparam logic [7:0] CH_PR_HI = 8'h7E;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_COL  = 2'd2;
  localparam logic [1:0] REG_ROW  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PUT    = 2'd1,
    ST_SCROLL = 2'd2,
    ST_CLEAR  = 2'd3
  } con_state_e;

  typedef enum logic {
    MV_COPY = 1'b0,
    MV_FILL = 1'b1
  } mv_mode_e;

  // row*cols+col as a sum of shifted rows, one term per set bit of cols
  function automatic logic [11:0] cell_index(input logic [7:0] row, input logic [7:0] col,
                                             input int cols);
    logic [11:0] acc;
    acc = {4'd0, col};
    for (int i = 0; i < 12; i++) begin
      if (cols[i]) acc = acc + ({4'd0, row} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/text_console_if.sv
// CPU IO bus of the text console: write/read strobes, address, data in and registered data out.
interface text_console_if;
  logic [7:0]  din;
  logic [11:0] address;
  logic        io_w_en;
  logic        io_r_en;
  logic [7:0]  dout;

  modport master (output din, output address, output io_w_en, output io_r_en, input dout);
  modport slave  (input din, input address, input io_w_en, input io_r_en, output dout);
endinterface

// File: rtl/text_console_mover.sv
// Bulk address sequencer: pipelined one-row scroll (copy then blank last row) or full-screen fill.
// Read data arrives one clock after r_addr_o and is written straight through in that cycle.
module console_mover
  import gpu_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  mv_mode_e    mode_i,
  output logic        busy_o,
  output logic        last_o,
  output logic        w_en_o,
  output logic [11:0] w_addr_o,
  output logic [7:0]  w_data_o,
  output logic [11:0] r_addr_o,
  input  logic [7:0]  r_data_i
);

  localparam logic [11:0] COLS_W        = 12'(COLS);
  localparam logic [11:0] LAST_CELL     = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROW_BASE = 12'(COLS * (ROWS - 1));

  logic        rd_en_q, rd_en_d, fill_en_q, fill_en_d, we_q, we_d, copy_q, copy_d;
  logic [11:0] rd_addr_q, rd_addr_d, fill_addr_q, fill_addr_d, waddr_q, waddr_d;

  always_comb begin
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    fill_en_d   = fill_en_q;
    fill_addr_d = fill_addr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    copy_d      = 1'b0;
    if (start_i) begin
      if (mode_i == MV_COPY) begin
        rd_en_d   = 1'b1;
        rd_addr_d = COLS_W;
        fill_en_d = 1'b0;
      end else begin
        rd_en_d     = 1'b0;
        fill_en_d   = 1'b1;
        fill_addr_d = 12'd1;
        we_d        = 1'b1;
        waddr_d     = 12'd0;
      end
    end else if (rd_en_q) begin
      // the read issued this cycle becomes next cycle's write one row up
      we_d    = 1'b1;
      copy_d  = 1'b1;
      waddr_d = rd_addr_q - COLS_W;
      if (rd_addr_q == LAST_CELL) begin
        rd_en_d     = 1'b0;
        fill_en_d   = 1'b1;
        fill_addr_d = LAST_ROW_BASE;
      end else begin
        rd_addr_d = rd_addr_q + 12'd1;
      end
    end else if (fill_en_q) begin
      we_d    = 1'b1;
      waddr_d = fill_addr_q;
      if (fill_addr_q == LAST_CELL) begin
        fill_en_d = 1'b0;
      end else begin
        fill_addr_d = fill_addr_q + 12'd1;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 12'd0;
      fill_en_q   <= 1'b0;
      fill_addr_q <= 12'd0;
      we_q        <= 1'b0;
      waddr_q     <= 12'd0;
      copy_q      <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      fill_en_q   <= fill_en_d;
      fill_addr_q <= fill_addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      copy_q      <= copy_d;
    end
  end

  assign busy_o   = rd_en_q | fill_en_q | we_q;
  assign last_o   = we_q & ~rd_en_q & ~fill_en_q;
  assign w_en_o   = we_q;
  assign w_addr_o = waddr_q;
  assign w_data_o = copy_q ? r_data_i : (we_q ? SPACE : 8'h00);
  assign r_addr_o = rd_addr_q;

endmodule

// File: rtl/text_console.sv
// Memory-mapped character console: register decode, cursor handling and single-cell writes;
// scrolling and clearing are delegated to console_mover.
module text_console
  import gpu_pkg::*;
#(
  parameter int          COLS = COLS_DEF,
  parameter int          ROWS = ROWS_DEF,
  parameter logic [11:0] BASE = 12'h090
) (
  input  logic           clk,
  input  logic           rst_n,
  text_console_if.slave  bus,
  output logic           v_w_en,
  output logic [11:0]    v_addr,
  output logic [7:0]     v_din,
  output logic [11:0]    v_r_addr,
  input  logic [7:0]     v_r_data,
  output logic           busy,
  output logic           done_interrupt_flag,
  input  logic           done_interrupt_flag_clr
);

  localparam logic [7:0] COLS_B   = 8'(COLS);
  localparam logic [7:0] ROWS_B   = 8'(ROWS);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  con_state_e  state_q, state_d;
  logic [7:0]  col_q, col_d, row_q, row_d, pw_din_q, pw_din_d, dout_q, dout_d;
  logic        ovr_q, ovr_d, ie_q, ie_d, flag_q, flag_d, pend_q, pend_d, pw_en_q, pw_en_d;
  logic [11:0] pw_addr_q, pw_addr_d, rel_s, mv_addr_s;
  logic        sel_s, wr_s, rd_s, idle_s, set_done_s;
  logic        mv_start_s, mv_busy_s, mv_last_s, mv_we_s;
  mv_mode_e    mv_mode_s;
  logic [7:0]  mv_data_s;

  assign rel_s  = bus.address - BASE;
  assign sel_s  = (rel_s[11:2] == 10'd0);
  assign wr_s   = bus.io_w_en & sel_s;
  assign rd_s   = bus.io_r_en & sel_s;
  assign idle_s = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    ovr_d      = ovr_q;
    ie_d       = ie_q;
    flag_d     = flag_q;
    pend_d     = 1'b0;
    pw_en_d    = 1'b0;
    pw_addr_d  = pw_addr_q;
    pw_din_d   = pw_din_q;
    dout_d     = dout_q;
    mv_start_s = 1'b0;
    mv_mode_s  = MV_FILL;
    set_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_s && rel_s[1:0] == REG_DATA) begin
          if (bus.din >= CH_PR_LO && bus.din <= CH_PR_HI) begin
            pw_en_d   = 1'b1;
            pw_addr_d = cell_index(row_q, col_q, COLS);
            pw_din_d  = bus.din;
            state_d   = ST_PUT;
            if (col_q == LAST_COL) begin
              col_d = 8'd0;
              if (row_q == LAST_ROW) pend_d = 1'b1;
              else row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end else if (bus.din == CH_CR) begin
            col_d = 8'd0;
          end else if (bus.din == CH_LF) begin
            col_d = 8'd0;
            if (row_q == LAST_ROW) begin
              state_d    = ST_SCROLL;
              mv_start_s = 1'b1;
              mv_mode_s  = MV_COPY;
            end else begin
              row_d = row_q + 8'd1;
            end
          end else if (bus.din == CH_BS) begin
            if (col_q != 8'd0) begin
              col_d     = col_q - 8'd1;
              pw_en_d   = 1'b1;
              pw_addr_d = cell_index(row_q, col_q - 8'd1, COLS);
              pw_din_d  = SPACE;
              state_d   = ST_PUT;
            end else begin
              col_d = col_q;
            end
          end else if (bus.din == CH_FF) begin
            col_d      = 8'd0;
            row_d      = 8'd0;
            state_d    = ST_CLEAR;
            mv_start_s = 1'b1;
            mv_mode_s  = MV_FILL;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUT: begin
        // a character in the bottom-right cell scrolls once its write is done
        if (pend_q) begin
          state_d    = ST_SCROLL;
          mv_start_s = 1'b1;
          mv_mode_s  = MV_COPY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCROLL, ST_CLEAR: begin
        if (mv_last_s || !mv_busy_s) begin
          state_d    = ST_IDLE;
          set_done_s = ie_q;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_s) begin
      case (rel_s[1:0])
        REG_DATA: ovr_d = ovr_q | ~idle_s;
        REG_CTRL: begin
          ovr_d = ovr_q & ~bus.din[1];
          ie_d  = bus.din[2];
        end
        REG_COL: begin
          if (!idle_s) ovr_d = 1'b1;
          else if (bus.din < COLS_B) col_d = bus.din;
          else col_d = col_q;
        end
        REG_ROW: begin
          if (!idle_s) ovr_d = 1'b1;
          else if (bus.din < ROWS_B) row_d = bus.din;
          else row_d = row_q;
        end
        default: ovr_d = ovr_q;
      endcase
    end else begin
      ovr_d = ovr_q;
    end

    if (done_interrupt_flag_clr) flag_d = 1'b0;
    else if (wr_s && rel_s[1:0] == REG_CTRL) flag_d = bus.din[3];
    else if (set_done_s) flag_d = 1'b1;
    else flag_d = flag_q;

    if (rd_s) begin
      case (rel_s[1:0])
        REG_DATA: dout_d = 8'h00;
        REG_CTRL: dout_d = {4'b0000, flag_q, ie_q, ovr_q, ~idle_s};
        REG_COL:  dout_d = col_q;
        REG_ROW:  dout_d = row_q;
        default:  dout_d = dout_q;
      endcase
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= 8'd0;
      row_q     <= 8'd0;
      ovr_q     <= 1'b0;
      ie_q      <= 1'b0;
      flag_q    <= 1'b0;
      pend_q    <= 1'b0;
      pw_en_q   <= 1'b0;
      pw_addr_q <= 12'd0;
      pw_din_q  <= 8'd0;
      dout_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ovr_q     <= ovr_d;
      ie_q      <= ie_d;
      flag_q    <= flag_d;
      pend_q    <= pend_d;
      pw_en_q   <= pw_en_d;
      pw_addr_q <= pw_addr_d;
      pw_din_q  <= pw_din_d;
      dout_q    <= dout_d;
    end
  end

  console_mover #(.COLS(COLS), .ROWS(ROWS)) u_mover (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mv_start_s),
    .mode_i   (mv_mode_s),
    .busy_o   (mv_busy_s),
    .last_o   (mv_last_s),
    .w_en_o   (mv_we_s),
    .w_addr_o (mv_addr_s),
    .w_data_o (mv_data_s),
    .r_addr_o (v_r_addr),
    .r_data_i (v_r_data)
  );

  // single-cell writes and mover writes never overlap in time
  assign v_w_en              = pw_en_q | mv_we_s;
  assign v_addr              = pw_en_q ? pw_addr_q : mv_addr_s;
  assign v_din               = pw_en_q ? pw_din_q : mv_data_s;
  assign busy                = ~idle_s;
  assign done_interrupt_flag = flag_q;
  assign bus.dout            = dout_q;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: expected cell writes and register reads are queued by the
// stimulus process and checked by a monitor on the falling clock edge.
module tb_text_console;
  import gpu_pkg::*;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  localparam logic [11:0] A_DATA = 12'h090;
  localparam logic [11:0] A_CTRL = 12'h091;
  localparam logic [11:0] A_COL  = 12'h092;
  localparam logic [11:0] A_ROW  = 12'h093;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_w_en, busy, flag, flag_clr, preload, rd_seen;
  logic [11:0] v_addr, v_r_addr;
  logic [7:0]  v_din, v_r_data;
  logic [7:0]  vram  [0:4095];
  logic [7:0]  model [0:4095];
  wr_t         exp_wr[$];
  logic [7:0]  exp_rd[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          busy_cnt = 0;

  always #5 clk = ~clk;

  text_console_if bus_if ();

  text_console #(.COLS(80), .ROWS(30), .BASE(12'h090)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .bus                     (bus_if),
    .v_w_en                  (v_w_en),
    .v_addr                  (v_addr),
    .v_din                   (v_din),
    .v_r_addr                (v_r_addr),
    .v_r_data                (v_r_data),
    .busy                    (busy),
    .done_interrupt_flag     (flag),
    .done_interrupt_flag_clr (flag_clr)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // text RAM model with one-clock read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) vram[i] <= pat(i);
    end else if (v_w_en) begin
      vram[v_addr] <= v_din;
    end
    v_r_data <= vram[v_r_addr];
    rd_seen  <= bus_if.io_r_en;
  end

  always @(negedge clk) begin
    wr_t e;
    if (v_w_en === 1'b1) begin
      wr_cnt++;
      n_checks++;
      if (v_addr >= 12'd2400) begin
        n_fail++;
        $display("FAIL wr_range actual=%0d required=<2400", v_addr);
      end
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=none", v_addr, v_din);
      end else begin
        e = exp_wr.pop_front();
        if (v_addr !== e.a || v_din !== e.d) begin
          n_fail++;
          $display("FAIL wr_match actual addr=%0d data=0x%0h required addr=%0d data=0x%0h",
                   v_addr, v_din, e.a, e.d);
        end
      end
    end
    if (rd_seen === 1'b1) begin
      n_checks++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read actual=0x%0h", bus_if.dout);
      end else if (bus_if.dout !== exp_rd[0]) begin
        n_fail++;
        $display("FAIL rd_match actual=0x%0h required=0x%0h", bus_if.dout, exp_rd[0]);
        void'(exp_rd.pop_front());
      end else begin
        void'(exp_rd.pop_front());
      end
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    exp_wr.push_back('{a: a, d: d});
    model[a] = d;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    bus_if.address = a;
    bus_if.din     = d;
    bus_if.io_w_en = 1'b1;
    @(posedge clk);
    #1;
    bus_if.io_w_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] exp);
    exp_rd.push_back(exp);
    bus_if.address = a;
    bus_if.io_r_en = 1'b1;
    @(posedge clk);
    #1;
    bus_if.io_r_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    int b0, w0;
    logic [7:0] old80;
    rst_n = 1'b0;
    preload = 1'b1;
    flag_clr = 1'b0;
    bus_if.din = 8'h00;
    bus_if.address = 12'h000;
    bus_if.io_w_en = 1'b0;
    bus_if.io_r_en = 1'b0;
    for (int i = 0; i < 4096; i++) model[i] = pat(i);
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    chk("rst_v_w_en", 32'(v_w_en), 32'd0);
    chk("rst_v_addr", 32'(v_addr), 32'd0);
    chk("rst_v_din", 32'(v_din), 32'd0);
    chk("rst_v_r_addr", 32'(v_r_addr), 32'd0);
    chk("rst_dout", 32'(bus_if.dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single printable character at the home position
    w0 = wr_cnt;
    push_wr(12'd0, 8'h41);
    wr(A_DATA, 8'h41);
    wait_idle(10, "put_A_idle");
    chk("put_A_writes", 32'(wr_cnt - w0), 32'd1);
    rd(A_COL, 8'd1);
    rd(A_ROW, 8'd0);

    // bottom-right character triggers a full scroll
    wr(A_COL, 8'd79);
    wr(A_ROW, 8'd29);
    old80 = model[80];
    push_wr(12'd2399, 8'h5A);
    for (int k = 0; k < 2320; k++) push_wr(12'(k), model[12'(k + 80)]);
    for (int k = 2320; k < 2400; k++) push_wr(12'(k), 8'h20);
    b0 = busy_cnt;
    wr(A_DATA, 8'h5A);
    wait_idle(3000, "scroll_idle");
    chk("scroll_busy_cycles_put_plus_2401", 32'(busy_cnt - b0), 32'd2402);
    chk("scroll_cell0", 32'(vram[0]), 32'(old80));
    chk("scroll_cell2320", 32'(vram[2320]), 32'h20);
    chk("scroll_cell2399", 32'(vram[2399]), 32'h20);
    rd(A_COL, 8'd0);
    rd(A_ROW, 8'd29);
    rd(A_CTRL, 8'h00);

    // clear with done interrupt enabled; a DATA write during CLEAR is an overrun
    wr(A_CTRL, 8'h04);
    for (int k = 0; k < 2400; k++) push_wr(12'(k), 8'h20);
    b0 = busy_cnt;
    wr(A_DATA, 8'h0C);
    wr(A_DATA, 8'h41);
    wait_idle(3000, "clear_idle");
    chk("clear_busy_cycles", 32'(busy_cnt - b0), 32'd2400);
    chk("clear_done_flag", 32'(flag), 32'd1);
    rd(A_CTRL, 8'h0E);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("flag_after_clr", 32'(flag), 32'd0);
    wr(A_CTRL, 8'h02);
    rd(A_CTRL, 8'h00);
    rd(A_COL, 8'd0);
    rd(A_ROW, 8'd0);

    // backspace mid-row and at column 0
    wr(A_COL, 8'd5);
    wr(A_ROW, 8'd3);
    push_wr(12'd244, 8'h20);
    wr(A_DATA, 8'h08);
    wait_idle(10, "bs_idle");
    rd(A_COL, 8'd4);
    wr(A_COL, 8'd0);
    w0 = wr_cnt;
    wr(A_DATA, 8'h08);
    repeat (3) @(posedge clk);
    #1;
    chk("bs_col0_no_write", 32'(wr_cnt - w0), 32'd0);
    rd(A_COL, 8'd0);

    // CR, LF, ignored code and out-of-range cursor writes
    wr(A_COL, 8'd10);
    wr(A_ROW, 8'd5);
    wr(A_DATA, 8'h0D);
    rd(A_COL, 8'd0);
    wr(A_COL, 8'd10);
    wr(A_DATA, 8'h0A);
    wr(A_DATA, 8'h07);
    wr(A_COL, 8'd80);
    wr(A_ROW, 8'd30);
    rd(A_COL, 8'd0);
    rd(A_ROW, 8'd6);
    rd(A_CTRL, 8'h00);
    rd(A_DATA, 8'h00);

    // LF on the last row, then reset at scroll cycle 100
    wr(A_ROW, 8'd29);
    for (int k = 0; k < 99; k++) push_wr(12'(k), model[12'(k + 80)]);
    wr(A_DATA, 8'h0A);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_all_writes_seen", 32'(exp_wr.size()), 32'd0);
    chk("abort_v_w_en", 32'(v_w_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_v_addr", 32'(v_addr), 32'd0);
    w0 = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("abort_no_writes_after", 32'(wr_cnt - w0), 32'd0);
    rd(A_COL, 8'd0);
    rd(A_ROW, 8'd0);
    rd(A_CTRL, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("end_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("end_rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
